// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stateful hazard controller for an in-order MIPS pipeline.
// Generates PC write-enable and per-latch advance/flush vectors. It handles
// load-use bubbles, data-cache freezes, fetch-miss bubbles, taken-branch
// flushes and a sticky halt. It also keeps a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int NSTAGES  = 4,
  parameter int LU_DELAY = 1,
  parameter int REGW     = 5,
  parameter int CNTW     = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                dmem_req,
  input  logic                idex_mem_read,
  input  logic [REGW-1:0]     idex_rd,
  input  logic [REGW-1:0]     ifid_rs,
  input  logic [REGW-1:0]     ifid_rt,
  input  logic                ifid_uses_rt,
  input  logic                branch_taken,
  input  logic                halt_in,
  input  logic [NSTAGES-1:0]  flush_req,
  output logic                pc_wen,
  output logic [NSTAGES-1:0]  latch_en,
  output logic [NSTAGES-1:0]  latch_flush,
  output logic                halted,
  output logic [CNTW-1:0]     stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LU     = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Reload value for the bubble counter when entering LU; the first bubble is
  // spent in RUN, and the last one in LU with lu_cnt==0.
  localparam logic [2:0] LU_INIT = (LU_DELAY > 1) ? 3'(LU_DELAY - 2) : 3'd0;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t     state;
  logic [2:0] lu_cnt;
  logic       freeze;
  logic       lu_hit;

  assign freeze = dmem_req & ~dhit;

  // Register 0 is hard-wired to zero, so it can never carry a real dependence.
  assign lu_hit = (LU_DELAY > 0) && idex_mem_read && (idex_rd != '0) &&
                  ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

  // Combinational pipeline control, in priority order.
  always_comb begin
    // NOTE: every output gets a default before the if-chain, so no path leaves
    // a value unassigned and no latch is inferred.
    pc_wen      = 1'b1;
    latch_en    = '1;
    latch_flush = flush_req;
    if (RST) begin
      pc_wen      = 1'b0;
      latch_en    = '0;
      latch_flush = '1;
    end else if (state == HALTED || freeze) begin
      pc_wen      = 1'b0;
      latch_en    = '0;
      latch_flush = '0;
    end else if (branch_taken) begin
      latch_flush[0] = 1'b1;
      latch_flush[1] = 1'b1;
    end else if (state == LU || lu_hit) begin
      pc_wen         = 1'b0;
      latch_en[0]    = 1'b0;
      latch_flush[1] = 1'b1;
    end else if (!ihit) begin
      pc_wen         = 1'b0;
      latch_flush[0] = 1'b1;
    end
  end

  // Control state, halt flag and bubble counter.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
      halted <= 1'b0;
    end else if (state == HALTED || freeze) begin
      state  <= state;
    end else if (halt_in) begin
      state  <= HALTED;
      halted <= 1'b1;
    end else if (branch_taken) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end else if (state == RUN) begin
      if (lu_hit && LU_DELAY > 1) begin
        state  <= LU;
        lu_cnt <= LU_INIT;
      end
    end else if (state == LU) begin
      if (lu_cnt == 3'd0) begin
        state <= RUN;
      end else begin
        lu_cnt <= lu_cnt - 3'd1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held outside of halt.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
    end else if (!pc_wen && state != HALTED && stall_cycles != CNT_MAX) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Three instances cover LU_DELAY
// of 1, 3 and 2. The LU_DELAY=1 instance uses a 4-bit counter so that its
// saturation can be reached quickly. Expected control vectors are queued when
// stimulus is applied, then popped and compared at the following negedge.
module tb_pipe_hazard_ctrl;

  localparam int NS = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ihit, dhit, dmem_req, idex_mem_read, ifid_uses_rt;
  logic          branch_taken, halt_in;
  logic [4:0]    idex_rd, ifid_rs, ifid_rt;
  logic [NS-1:0] flush_req;

  logic          pc_a, pc_b, pc_c, hl_a, hl_b, hl_c;
  logic [NS-1:0] en_a, en_b, en_c, fl_a, fl_b, fl_c;
  logic [3:0]    sc_a;
  logic [15:0]   sc_b, sc_c;

  int sel = 0;
  logic          pc_o, hl_o;
  logic [NS-1:0] en_o, fl_o;
  logic [15:0]   sc_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string         tag;
    logic          pc;
    logic [NS-1:0] en;
    logic [NS-1:0] fl;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.NSTAGES(NS), .LU_DELAY(1), .REGW(5), .CNTW(4)) dut_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
    .halt_in(halt_in), .flush_req(flush_req), .pc_wen(pc_a), .latch_en(en_a),
    .latch_flush(fl_a), .halted(hl_a), .stall_cycles(sc_a));

  pipe_hazard_ctrl #(.NSTAGES(NS), .LU_DELAY(3), .REGW(5), .CNTW(16)) dut_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
    .halt_in(halt_in), .flush_req(flush_req), .pc_wen(pc_b), .latch_en(en_b),
    .latch_flush(fl_b), .halted(hl_b), .stall_cycles(sc_b));

  pipe_hazard_ctrl #(.NSTAGES(NS), .LU_DELAY(2), .REGW(5), .CNTW(16)) dut_c (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
    .halt_in(halt_in), .flush_req(flush_req), .pc_wen(pc_c), .latch_en(en_c),
    .latch_flush(fl_c), .halted(hl_c), .stall_cycles(sc_c));

  // Route the instance under test to a common set of observation signals.
  always_comb begin
    pc_o = pc_a; en_o = en_a; fl_o = fl_a; hl_o = hl_a; sc_o = {12'd0, sc_a};
    if (sel == 1) begin
      pc_o = pc_b; en_o = en_b; fl_o = fl_b; hl_o = hl_b; sc_o = sc_b;
    end else if (sel == 2) begin
      pc_o = pc_c; en_o = en_c; fl_o = fl_c; hl_o = hl_c; sc_o = sc_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b0; idex_mem_read = 1'b0;
    idex_rd = '0; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0;
    branch_taken = 1'b0; halt_in = 1'b0; flush_req = '0;
  endtask

  // Queue the expected controls for the inputs just applied, then compare
  // at the negedge and advance to just after the next rising edge.
  task automatic cycle(input string tag, input logic pc, input logic [NS-1:0] en,
                       input logic [NS-1:0] fl);
    exp_t e;
    sb.push_back('{tag: tag, pc: pc, en: en, fl: fl});
    @(negedge CLK);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_pc_wen"},   32'(pc_o), 32'(e.pc));
      check({e.tag, "_latch_en"}, 32'(en_o), 32'(e.en));
      check({e.tag, "_flush"},    32'(fl_o), 32'(e.fl));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int which);
    sel = which;
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    check("rst_pc_wen",   32'(pc_o), 32'd0);
    check("rst_latch_en", 32'(en_o), 32'd0);
    check("rst_flush",    32'(fl_o), 32'hF);
    check("rst_stall",    32'(sc_o), 32'd0);
    check("rst_halted",   32'(hl_o), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle_inputs();

    // ---- LU_DELAY=1: rs and rt dependences, reg 0, fetch miss, freeze ----
    do_reset(0);
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs = 5'd5;
    cycle("lu1_rs_bubble", 1'b0, 4'b1110, 4'b0010);
    idex_mem_read = 1'b0; idex_rd = 5'd0;
    cycle("lu1_rs_after", 1'b1, 4'b1111, 4'b0000);
    check("lu1_stall_cnt", 32'(sc_o), 32'd1);

    idex_mem_read = 1'b1; idex_rd = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    ifid_uses_rt = 1'b0;
    cycle("lu1_rt_unused", 1'b1, 4'b1111, 4'b0000);
    ifid_uses_rt = 1'b1;
    cycle("lu1_rt_bubble", 1'b0, 4'b1110, 4'b0010);
    idle_inputs();
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0;
    cycle("lu_reg0", 1'b1, 4'b1111, 4'b0000);
    idle_inputs();
    flush_req = 4'b0100;
    cycle("flush_passthru", 1'b1, 4'b1111, 4'b0100);
    ihit = 1'b0; flush_req = 4'b1000;
    cycle("fetch_miss", 1'b0, 4'b1111, 4'b1001);
    ihit = 1'b1; dmem_req = 1'b1; dhit = 1'b0; flush_req = 4'b1111;
    cycle("freeze", 1'b0, 4'b0000, 4'b0000);
    idle_inputs();
    cycle("freeze_release", 1'b1, 4'b1111, 4'b0000);
    check("misc_stall_cnt", 32'(sc_o), 32'd4);

    // ---- LU_DELAY=3 with a freeze in the second bubble ----
    do_reset(1);
    idex_mem_read = 1'b1; idex_rd = 5'd9; ifid_rs = 5'd9;
    cycle("lu3_b1", 1'b0, 4'b1110, 4'b0010);
    idex_mem_read = 1'b0; dmem_req = 1'b1; dhit = 1'b0;
    cycle("lu3_freeze", 1'b0, 4'b0000, 4'b0000);
    dhit = 1'b1;
    cycle("lu3_b2", 1'b0, 4'b1110, 4'b0010);
    dmem_req = 1'b0;
    cycle("lu3_b3", 1'b0, 4'b1110, 4'b0010);
    cycle("lu3_resume", 1'b1, 4'b1111, 4'b0000);
    check("lu3_stall_cnt", 32'(sc_o), 32'd4);

    // ---- LU_DELAY=2, taken branch in the middle of the stall ----
    do_reset(2);
    idex_mem_read = 1'b1; idex_rd = 5'd4; ifid_rt = 5'd4; ifid_uses_rt = 1'b1;
    cycle("lu2_b1", 1'b0, 4'b1110, 4'b0010);
    idex_mem_read = 1'b0; branch_taken = 1'b1;
    cycle("lu2_branch", 1'b1, 4'b1111, 4'b0011);
    branch_taken = 1'b0;
    cycle("lu2_run_after", 1'b1, 4'b1111, 4'b0000);
    check("lu2_stall_cnt", 32'(sc_o), 32'd1);

    // ---- halt held off by a data miss, then sticky ----
    do_reset(0);
    halt_in = 1'b1; dmem_req = 1'b1; dhit = 1'b0;
    cycle("halt_frz1", 1'b0, 4'b0000, 4'b0000);
    cycle("halt_frz2", 1'b0, 4'b0000, 4'b0000);
    check("halt_not_yet", 32'(hl_o), 32'd0);
    dhit = 1'b1;
    cycle("halt_enter", 1'b1, 4'b1111, 4'b0000);
    check("halted_set", 32'(hl_o), 32'd1);
    idle_inputs();
    ihit = 1'b0; flush_req = 4'b1111; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cycle("halted_hold", 1'b0, 4'b0000, 4'b0000);
    check("halted_sticky", 32'(hl_o), 32'd1);
    check("halt_stall_cnt", 32'(sc_o), 32'd2);

    // ---- counter saturation (CNTW=4), then asynchronous reset mid-stall ----
    do_reset(0);
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) cycle("sat_miss", 1'b0, 4'b1111, 4'b0001);
    check("stall_saturated", 32'(sc_o), 32'd15);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_cnt",   32'(sc_o), 32'd0);
    check("async_rst_pc",    32'(pc_o), 32'd0);
    check("async_rst_en",    32'(en_o), 32'd0);
    check("async_rst_flush", 32'(fl_o), 32'hF);
    @(posedge CLK);
    #1;
    check("rst_held_cnt",   32'(sc_o), 32'd0);
    check("rst_held_flush", 32'(fl_o), 32'hF);
    RST = 1'b0;
    ihit = 1'b1;
    cycle("post_rst_run", 1'b1, 4'b1111, 4'b0000);
    check("post_rst_cnt", 32'(sc_o), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net in case the stimulus ever stalls on a clock event.
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised, stateful successor to the combinational pipeline hazard unit.
- Drives PC write-enable, plus per-latch enable and flush vectors, for an NSTAGES-latch in-order MIPS pipeline.
- Handles load-use bubbles of configurable length, full freeze on data-cache miss, instruction-fetch miss bubbles, taken-branch flushes and a sticky halt.
- Keeps a saturating stall-cycle performance counter.
- Sits between the datapath latches and the cache interface.

Parameters:
NSTAGES, 4, number of pipeline latches (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB, ...); minimum 4
LU_DELAY, 1, load-use bubble cycles; 0 disables load-use stalling; maximum 7
REGW, 5, register index width
CNTW, 16, stall counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dmem_req  in  1  EX/MEM holds a load or store
idex_mem_read  in  1  ID/EX holds a load
idex_rd  in  REGW  load destination register
ifid_rs  in  REGW  IF/ID source register rs
ifid_rt  in  REGW  IF/ID source register rt
ifid_uses_rt  in  1  IF/ID instruction reads rt
branch_taken  in  1  branch/jump resolved taken in EX
halt_in  in  1  halt instruction present in MEM/WB
flush_req  in  NSTAGES  external per-latch flush request
pc_wen  out  1  PC update enable
latch_en  out  NSTAGES  per-latch advance enable
latch_flush  out  NSTAGES  per-latch clear to bubble; wins over latch_en inside the latch
halted  out  1  sticky halt indication
stall_cycles  out  CNTW  saturating count of cycles with pc_wen=0

Behaviour:
- State register: {RUN, LU, HALTED}, plus lu_cnt (3 bits).
- RST asserted (asynchronous): state=RUN, lu_cnt=0, halted=0, stall_cycles=0.
- Outputs while RST is high: pc_wen=0, latch_en=0, latch_flush=all ones.
- Defaults, out of reset: pc_wen=1, latch_en=all ones, latch_flush=flush_req.
- Conditions evaluated in priority order each cycle:
  1. HALTED: pc_wen=0, latch_en=0, latch_flush=0; flush_req ignored. Only RST exits this state.
  2. Freeze, when dmem_req & !dhit: pc_wen=0, latch_en=0, latch_flush=0. No state change and lu_cnt holds. Upstream inputs are stable while frozen.
  3. branch_taken: latch_flush[0]=latch_flush[1]=1, pc_wen=1. In LU state, branch wins: state goes to RUN and lu_cnt=0.
  4. Load-use:
     - Hazard condition (lu_hit): LU_DELAY>0 & idex_mem_read & idex_rd!=0 & (idex_rd==ifid_rs | (ifid_uses_rt & idex_rd==ifid_rt)).
     - In RUN with lu_hit, or in LU state: pc_wen=0, latch_en[0]=0, latch_flush[1]=1. Later latches advance.
     - RUN & lu_hit with LU_DELAY>1: go to LU and set lu_cnt=LU_DELAY-2.
     - In LU: if lu_cnt==0 go to RUN, else decrement.
     - Net effect: exactly LU_DELAY bubble cycles, not counting freeze cycles.
  5. Fetch miss, when !ihit: pc_wen=0, latch_flush[0]=1 (bubble into IF/ID). Later latches advance.
- halt_in & not frozen & state!=HALTED: go to HALTED and set halted=1 on the next edge.
- stall_cycles: increments on every non-reset edge where pc_wen==0 and state!=HALTED. Saturates at 2^CNTW-1 and does not wrap.
- Outputs are combinational from state and inputs; no added latency beyond the registered state.
- Register 0 never triggers a load-use stall.

Test Plan:
- Load-use, LU_DELAY=1: load r5 in ID/EX, IF/ID reads rs=5. Required: one cycle with pc_wen=0, latch_en[0]=0, latch_flush[1]=1; normal flow on the next cycle; stall_cycles=1.
- LU_DELAY=3, with a dhit miss injected in the 2nd bubble cycle. Required: 3 bubble cycles plus 1 freeze cycle; pc_wen low for 4 cycles total; stall_cycles=4.
- idex_rd=0, ifid_rs=0, idex_mem_read=1. Required: no stall, pc_wen=1.
- branch_taken during an LU stall (LU_DELAY=2). Required: latch_flush[1:0]=2'b11, pc_wen=1, state RUN on the next cycle.
- halt_in=1 with dmem_req=1, dhit=0 for 2 cycles, then dhit=1. Required: halted rises on the edge after dhit=1; afterwards latch_en=0 and pc_wen=0 indefinitely; stall_cycles frozen.
- CNTW=4, force 20 stall cycles. Required: stall_cycles=15. Assert RST mid-stall. Required: all state cleared asynchronously and latch_flush=all ones while RST is high.
